// File: rtl/mdc_stim_driver.sv
// mdc_stim_driver: loads one matrix and its mode from the host, replays it to
// MDC as a burst, and returns MDC's result (or a timeout abort) to the host.
module mdc_stim_driver #(
    parameter int DATA_W  = 15,
    parameter int MODE_W  = 9,
    parameter int OUT_W   = 207,
    parameter int N_ELEM  = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [MODE_W-1:0] ld_mode,
    output logic              in_valid,
    output logic [DATA_W-1:0] in_data,
    output logic [MODE_W-1:0] in_mode,
    input  logic              out_valid,
    input  logic [OUT_W-1:0]  out_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic              res_tmo,
    output logic              busy
);

    localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int KW = CW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(N_ELEM - 1);
    localparam logic [KW-1:0] END_K    = KW'(N_ELEM);
    localparam logic [WW-1:0] LAST_W   = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        LOAD,
        SEND,
        WAIT,
        HOLD
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [KW-1:0]     k;
    logic [WW-1:0]     wcnt;
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] elem [N_ELEM];

    logic              accept;
    logic [DATA_W-1:0] first_data;
    logic [MODE_W-1:0] first_mode;

    assign accept = (state == LOAD) && ld_valid && ld_ready;

    // Element 0 may be the one being accepted right now for a 1-element matrix,
    // so the first burst word bypasses the buffer in that case.
    assign first_data = (cnt == '0) ? ld_data : elem[0];
    assign first_mode = (cnt == '0) ? ld_mode : mode;

    // Matrix buffer; every entry is rewritten before each replay, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            elem[cnt] <= ld_data;
        end
    end

    // Control FSM with all host- and MDC-facing outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            k         <= '0;
            wcnt      <= '0;
            mode      <= '0;
            ld_ready  <= 1'b1;
            in_valid  <= 1'b0;
            in_data   <= '0;
            in_mode   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tmo   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        if (cnt == '0) begin
                            mode <= ld_mode;
                        end
                        if (cnt == LAST_IDX) begin
                            state    <= SEND;
                            cnt      <= '0;
                            k        <= KW'(1);
                            ld_ready <= 1'b0;
                            busy     <= 1'b1;
                            in_valid <= 1'b1;
                            in_data  <= first_data;
                            in_mode  <= first_mode;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                SEND: begin
                    if (k == END_K) begin
                        state    <= WAIT;
                        wcnt     <= '0;
                        in_valid <= 1'b0;
                        in_data  <= '0;
                        in_mode  <= '0;
                    end else begin
                        in_data <= elem[k[CW-1:0]];
                        in_mode <= '0;
                        k       <= k + KW'(1);
                    end
                end
                WAIT: begin
                    wcnt <= wcnt + WW'(1);
                    // A result arriving on the timeout cycle still counts
                    if (out_valid) begin
                        state     <= HOLD;
                        res_valid <= 1'b1;
                        res_data  <= out_data;
                        res_tmo   <= 1'b0;
                    end else if (wcnt == LAST_W) begin
                        state     <= HOLD;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_tmo   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        res_valid <= 1'b0;
                        res_data  <= '0;
                        res_tmo   <= 1'b0;
                        busy      <= 1'b0;
                        ld_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdc_stim_driver.sv
// tb_mdc_stim_driver: directed and randomized transactions against a
// transaction-level model of load, burst, result timing and handoff.
module tb_mdc_stim_driver;

    localparam int DATA_W  = 15;
    localparam int MODE_W  = 9;
    localparam int OUT_W   = 207;
    localparam int N_ELEM  = 16;
    localparam int TIMEOUT = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data = '0;
    logic [MODE_W-1:0] ld_mode = '0;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [MODE_W-1:0] in_mode;
    logic              out_valid = 1'b0;
    logic [OUT_W-1:0]  out_data = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [OUT_W-1:0]  res_data;
    logic              res_tmo;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] mat [N_ELEM];

    mdc_stim_driver #(
        .DATA_W (DATA_W),
        .MODE_W (MODE_W),
        .OUT_W  (OUT_W),
        .N_ELEM (N_ELEM),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_data  (ld_data),
        .ld_mode  (ld_mode),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_data (out_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_tmo  (res_tmo),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OUT_W-1:0] got,
                         input logic [OUT_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [OUT_W-1:0] rand_out();
        logic [223:0] w;
        w = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom};
        return w[OUT_W-1:0];
    endfunction

    // One host transaction. d = cycle (1-based, after the last burst cycle)
    // at which MDC pulses out_valid; d outside 1..TIMEOUT means it never
    // answers in time. rst_at >= 0 aborts with a reset at that burst cycle.
    task automatic run_txn(input logic [MODE_W-1:0] m, input bit gap,
                           input int d, input int hold_n,
                           input logic [OUT_W-1:0] rdata, input int rst_at);
        int idx;
        int guard;
        int exp_lat;
        bit early;
        bit moved;
        logic [OUT_W-1:0] exp_data;
        logic exp_tmo;
        idx = 0;
        guard = 0;
        early = 0;
        moved = 0;
        check("ld_ready_idle", ld_ready, 1);
        // Load phase; ld_ready seen at a falling edge is what the next
        // rising edge samples
        while (idx < N_ELEM) begin
            ld_valid = gap ? (guard % 2 == 1) : 1'b1;
            ld_data = ld_valid ? mat[idx] : DATA_W'($urandom);
            ld_mode = (idx == 0) ? m : MODE_W'($urandom);
            out_valid = gap ? 1'($urandom % 2) : 1'b0;
            out_data = rand_out();
            if (ld_valid && ld_ready) idx++;
            guard++;
            tick();
            if (guard > 4 * N_ELEM && idx < N_ELEM) begin
                check("load_stall", idx, N_ELEM);
                break;
            end
        end
        ld_valid = 1'b0;
        out_valid = 1'b0;
        // Burst phase: starts the cycle after the last element is accepted
        for (int c = 0; c < N_ELEM; c++) begin
            if (c == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_in_valid", in_valid, 0);
                check("rst_ld_ready", ld_ready, 1);
                check("rst_busy", busy, 0);
                return;
            end
            check($sformatf("burst_valid%0d", c), in_valid, 1);
            check($sformatf("burst_data%0d", c), in_data, mat[c]);
            check($sformatf("burst_mode%0d", c), in_mode,
                  (c == 0) ? m : '0);
            if (c == 0) begin
                check("burst_busy", busy, 1);
                check("burst_ld_ready", ld_ready, 0);
            end
            tick();
        end
        check("post_in_valid", in_valid, 0);
        check("post_in_data", in_data, 0);
        // Result appears one cycle after out_valid; a timeout is decided in
        // the TIMEOUT-th wait cycle and shows up one cycle later as well
        if (d >= 1 && d <= TIMEOUT) begin
            exp_lat = d + 1;
            exp_data = rdata;
            exp_tmo = 1'b0;
        end else begin
            exp_lat = TIMEOUT + 1;
            exp_data = '0;
            exp_tmo = 1'b1;
        end
        for (int j = 1; j < exp_lat; j++) begin
            if (res_valid !== 1'b0) early = 1;
            out_valid = (j == d);
            out_data = (j == d) ? rdata : rand_out();
            tick();
        end
        out_valid = 1'b0;
        check("res_early", early, 0);
        check("res_valid", res_valid, 1);
        check("res_data", res_data, exp_data);
        check("res_tmo", res_tmo, exp_tmo);
        // Hold phase: stray out_valid pulses must not disturb the result
        for (int h = 0; h < hold_n; h++) begin
            res_ready = 1'b0;
            out_valid = 1'($urandom % 2);
            out_data = rand_out();
            tick();
            if (res_valid !== 1'b1 || res_data !== exp_data ||
                res_tmo !== exp_tmo || ld_ready !== 1'b0)
                moved = 1;
        end
        out_valid = 1'b0;
        check("hold_stable", moved, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("handoff_res_valid", res_valid, 0);
        check("handoff_ld_ready", ld_ready, 1);
        check("handoff_busy", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int d;
        int rs;
        // Reset held two cycles
        rst = 1'b1;
        tick();
        tick();
        check("reset_in_valid", in_valid, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_ld_ready", ld_ready, 1);
        check("reset_in_data", in_data, 0);
        rst = 1'b0;
        tick();

        // Ascending matrix, answer after 5 cycles, host stalls 10 cycles
        for (int i = 0; i < N_ELEM; i++) mat[i] = DATA_W'(i + 1);
        run_txn(9'h0A3, 1'b0, 5, 10, OUT_W'(207'h1234), -1);
        // MDC never answers
        run_txn(9'h0A3, 1'b0, 0, 2, '0, -1);
        // Gapped load with spurious out_valid during LOAD
        run_txn(9'h0A3, 1'b1, 5, 0, rand_out(), -1);
        // Answer on the very last allowed cycle wins over the timeout
        run_txn(9'h155, 1'b0, TIMEOUT, 1, rand_out(), -1);
        // Reset mid-burst, then a fresh descending load
        run_txn(9'h0A3, 1'b0, 5, 0, rand_out(), 7);
        for (int i = 0; i < N_ELEM; i++) mat[i] = DATA_W'(N_ELEM - i);
        run_txn(9'h011, 1'b0, 3, 1, rand_out(), -1);

        // Randomized transactions
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < N_ELEM; i++) mat[i] = DATA_W'($urandom);
            r = int'($urandom % 12);
            if (r == 0) d = TIMEOUT + 1;
            else if (r == 1) d = TIMEOUT;
            else d = 1 + int'($urandom % 30);
            rs = ($urandom % 8 == 0) ? int'($urandom % N_ELEM) : -1;
            run_txn(MODE_W'($urandom), 1'($urandom % 2), d,
                    int'($urandom % 5), rand_out(), rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
